// File: rtl/eth_mdio_pkg.sv
// eth_mdio_pkg
// Shared definitions for the MII management frame engine: FSM state enum,
// start-of-frame (ST) codes, operation codes for Clause 22 and Clause 45,
// frame field lengths and the op-code classification helpers.
package eth_mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_CMD  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4
  } mdio_state_e;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WR    = 2'b01;
  localparam logic [1:0] OP_C22_RD    = 2'b10;
  localparam logic [1:0] OP_C45_ADDR  = 2'b00;
  localparam logic [1:0] OP_C45_WR    = 2'b01;
  localparam logic [1:0] OP_C45_RDINC = 2'b10;
  localparam logic [1:0] OP_C45_RD    = 2'b11;

  localparam int unsigned CMD_LEN  = 14;
  localparam int unsigned TA_LEN   = 2;
  localparam int unsigned DATA_LEN = 16;

  // Clause 45 accepts every op code; Clause 22 only write and read.
  function automatic logic op_is_valid(input logic cl45, input logic [1:0] op);
    logic ok;
    if (cl45) begin
      ok = 1'b1;
    end else begin
      ok = (op == OP_C22_WR) || (op == OP_C22_RD);
    end
    return ok;
  endfunction

  // Frames whose data phase is driven by the PHY.
  function automatic logic op_is_read(input logic cl45, input logic [1:0] op);
    logic rd;
    if (cl45) begin
      rd = (op == OP_C45_RD) || (op == OP_C45_RDINC);
    end else begin
      rd = (op == OP_C22_RD);
    end
    return rd;
  endfunction

endpackage

// File: rtl/eth_mdio_rxshift.sv
// eth_mdio_rxshift
// Serial-to-parallel capture of the 16-bit read data field.
// Ports:
//   clk, rst_n   host clock, synchronous active-low reset
//   shift_en     shift mdi in (one pulse per DATA slot of a read frame)
//   load_en      transfer the completed word to rd_data (last DATA slot)
//   mdi          serial data in, MSB first
//   rx_next      word as it will look after the current bit is shifted in
//   rd_data      last completed read word (registered)
module eth_mdio_rxshift
  import eth_mdio_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                shift_en,
  input  logic                load_en,
  input  logic                mdi,
  output logic [DATA_LEN-1:0] rx_next,
  output logic [DATA_LEN-1:0] rd_data
);

  // Only 15 bits are stored; the 16th arrives together with load_en.
  logic [DATA_LEN-2:0] sr_q, sr_d;
  logic [DATA_LEN-1:0] rd_data_q, rd_data_d;

  assign rx_next = {sr_q, mdi};
  assign rd_data = rd_data_q;

  // Next-state for the shift register and the parallel output word.
  always_comb begin
    sr_d      = sr_q;
    rd_data_d = rd_data_q;
    if (shift_en) begin
      sr_d = {sr_q[DATA_LEN-3:0], mdi};
    end else begin
      sr_d = sr_q;
    end
    if (load_en) begin
      rd_data_d = rx_next;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q      <= {(DATA_LEN-1){1'b0}};
      rd_data_q <= {DATA_LEN{1'b0}};
    end else begin
      sr_q      <= sr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/eth_mdio_engine.sv
// eth_mdio_engine
// MII management frame engine: on an accepted Start it serialises
// preamble, ST/OP/PHY/REG command, turnaround and data, one bit per
// MdcEn_n slot, captures read data and tracks link status.
// Optional macro ETH_MDIO_CL45_EN adds the Cl45 input (Clause 45 frames).
// Ports:
//   Clk, Reset_n           host clock, synchronous active-low reset
//   MdcEn_n                one-cycle high pulse per MDC period (slot boundary)
//   Start/Op/Cl45/NoPre    frame request, latched when accepted in IDLE
//   PhyAddr/RegAddr/WrData frame fields, latched with Start
//   Mdi                    MDIO pad input
//   Mdo/MdoEn              MDIO pad output data and enable (registered)
//   Busy/Done              frame in progress / one-cycle end-of-frame pulse
//   RdData/RdValid         last read word / pulse with Done on reads
//   LinkFail               inverse of link bit from reads of LINK_REG
module eth_mdio_engine
  import eth_mdio_pkg::*;
#(
  parameter int unsigned PRE_LEN  = 32,
  parameter logic [4:0]  LINK_REG = 5'h01,
  parameter int unsigned LINK_BIT = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MdcEn_n,
  input  logic        Start,
  input  logic [1:0]  Op,
`ifdef ETH_MDIO_CL45_EN
  input  logic        Cl45,
`endif
  input  logic        NoPre,
  input  logic [4:0]  PhyAddr,
  input  logic [4:0]  RegAddr,
  input  logic [15:0] WrData,
  input  logic        Mdi,
  output logic        Mdo,
  output logic        MdoEn,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] RdData,
  output logic        RdValid,
  output logic        LinkFail
);

  logic cl45_in;
`ifdef ETH_MDIO_CL45_EN
  assign cl45_in = Cl45;
`else
  assign cl45_in = 1'b0;
`endif

  mdio_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // begun_q: first pulse after acceptance has opened slot 0
  logic        begun_q, begun_d;
  logic [1:0]  op_q, op_d;
  logic        cl45_q, cl45_d;
  logic        is_rd_q, is_rd_d;
  logic [4:0]  phy_q, phy_d;
  logic [4:0]  reg_q, reg_d;
  logic [15:0] wr_q, wr_d;
  logic        mdo_q, mdo_d;
  logic        mdo_en_q, mdo_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_valid_q, rd_valid_d;
  logic        link_fail_q, link_fail_d;

  logic        shift_en, load_en, new_slot;
  logic [1:0]  drive;
  logic [13:0] cmd_word;
  logic [15:0] rx_next;

  assign cmd_word = {(cl45_q ? ST_C45 : ST_C22), op_q, phy_q, reg_q};

  // {MdoEn, Mdo} for a slot; reads release the line from TA onward.
  function automatic logic [1:0] slot_drive(input mdio_state_e st, input logic [3:0] cnt,
                                            input logic [13:0] cmd, input logic [15:0] wd,
                                            input logic rd);
    logic [1:0] r;
    case (st)
      S_PRE:   r = 2'b11;
      S_CMD:   r = {1'b1, cmd[4'd13 - cnt]};
      S_TA:    r = rd ? 2'b01 : {1'b1, (cnt[0] == 1'b0)};
      S_DATA:  r = rd ? 2'b01 : {1'b1, wd[4'd15 - cnt]};
      default: r = 2'b01;
    endcase
    return r;
  endfunction

  eth_mdio_rxshift u_rxshift (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .shift_en (shift_en),
    .load_en  (load_en),
    .mdi      (Mdi),
    .rx_next  (rx_next),
    .rd_data  (RdData)
  );

  // Frame sequencing: request acceptance, slot counting, output drive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    begun_d     = begun_q;
    op_d        = op_q;
    cl45_d      = cl45_q;
    is_rd_d     = is_rd_q;
    phy_d       = phy_q;
    reg_d       = reg_q;
    wr_d        = wr_q;
    mdo_d       = mdo_q;
    mdo_en_d    = mdo_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_valid_d  = 1'b0;
    link_fail_d = link_fail_q;
    shift_en    = 1'b0;
    load_en     = 1'b0;
    new_slot    = 1'b0;
    drive       = 2'b01;

    case (state_q)
      S_IDLE: begin
        cnt_d    = 6'd0;
        begun_d  = 1'b0;
        mdo_d    = 1'b1;
        mdo_en_d = 1'b0;
        busy_d   = 1'b0;
        if (Start && op_is_valid(cl45_in, Op)) begin
          op_d    = Op;
          cl45_d  = cl45_in;
          is_rd_d = op_is_read(cl45_in, Op);
          phy_d   = PhyAddr;
          reg_d   = RegAddr;
          wr_d    = WrData;
          busy_d  = 1'b1;
          state_d = NoPre ? S_CMD : S_PRE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE, S_CMD, S_TA, S_DATA: begin
        if (MdcEn_n) begin
          new_slot = 1'b1;
          if (!begun_q) begin
            // This pulse only opens slot 0 of the current state.
            begun_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
            case (state_q)
              S_PRE: begin
                if (cnt_q == 6'(PRE_LEN - 1)) begin
                  state_d = S_CMD;
                  cnt_d   = 6'd0;
                end else begin
                  state_d = S_PRE;
                end
              end
              S_CMD: begin
                if (cnt_q == 6'(CMD_LEN - 1)) begin
                  state_d = S_TA;
                  cnt_d   = 6'd0;
                end else begin
                  state_d = S_CMD;
                end
              end
              S_TA: begin
                if (cnt_q == 6'(TA_LEN - 1)) begin
                  state_d = S_DATA;
                  cnt_d   = 6'd0;
                end else begin
                  state_d = S_TA;
                end
              end
              S_DATA: begin
                // Mdi is sampled on the pulse that ends each DATA slot.
                shift_en = is_rd_q;
                if (cnt_q == 6'(DATA_LEN - 1)) begin
                  state_d  = S_IDLE;
                  cnt_d    = 6'd0;
                  begun_d  = 1'b0;
                  new_slot = 1'b0;
                  mdo_d    = 1'b1;
                  mdo_en_d = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  if (is_rd_q) begin
                    load_en    = 1'b1;
                    rd_valid_d = 1'b1;
                    if (reg_q == LINK_REG) begin
                      link_fail_d = ~rx_next[LINK_BIT];
                    end else begin
                      link_fail_d = link_fail_q;
                    end
                  end else begin
                    load_en = 1'b0;
                  end
                end else begin
                  state_d = S_DATA;
                end
              end
              default: state_d = S_IDLE;
            endcase
          end
        end else begin
          new_slot = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase

    if (new_slot) begin
      drive    = slot_drive(state_d, cnt_d[3:0], cmd_word, wr_q, is_rd_q);
      mdo_en_d = drive[1];
      mdo_d    = drive[0];
    end else begin
      drive = 2'b01;
    end
  end

  // State, latched request and registered outputs with synchronous reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 6'd0;
      begun_q     <= 1'b0;
      op_q        <= 2'b00;
      cl45_q      <= 1'b0;
      is_rd_q     <= 1'b0;
      phy_q       <= 5'd0;
      reg_q       <= 5'd0;
      wr_q        <= 16'd0;
      mdo_q       <= 1'b1;
      mdo_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      begun_q     <= begun_d;
      op_q        <= op_d;
      cl45_q      <= cl45_d;
      is_rd_q     <= is_rd_d;
      phy_q       <= phy_d;
      reg_q       <= reg_d;
      wr_q        <= wr_d;
      mdo_q       <= mdo_d;
      mdo_en_q    <= mdo_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      link_fail_q <= link_fail_d;
    end
  end

  assign Mdo      = mdo_q;
  assign MdoEn    = mdo_en_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign RdValid  = rd_valid_q;
  assign LinkFail = link_fail_q;

endmodule

// File: tb/tb_eth_mdio_engine.sv
// tb_eth_mdio_engine
// Directed bench for eth_mdio_engine: drives frames with an MdcEn_n pulse
// every fourth clock, records the Mdo/MdoEn value held in each slot and
// compares frame fields, timing and read results against hand-computed values.
module tb_eth_mdio_engine;

  logic        Clk = 1'b0;
  logic        Reset_n, MdcEn_n, Start, NoPre, Mdi;
  logic [1:0]  Op;
  logic [4:0]  PhyAddr, RegAddr;
  logic [15:0] WrData;
  logic        Mdo, MdoEn, Busy, Done, RdValid, LinkFail;
  logic [15:0] RdData;
`ifdef ETH_MDIO_CL45_EN
  logic        Cl45;
`endif

  always #5 Clk = ~Clk;

  eth_mdio_engine #(.PRE_LEN(32), .LINK_REG(5'h01), .LINK_BIT(2)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .MdcEn_n  (MdcEn_n),
    .Start    (Start),
    .Op       (Op),
`ifdef ETH_MDIO_CL45_EN
    .Cl45     (Cl45),
`endif
    .NoPre    (NoPre),
    .PhyAddr  (PhyAddr),
    .RegAddr  (RegAddr),
    .WrData   (WrData),
    .Mdi      (Mdi),
    .Mdo      (Mdo),
    .MdoEn    (MdoEn),
    .Busy     (Busy),
    .Done     (Done),
    .RdData   (RdData),
    .RdValid  (RdValid),
    .LinkFail (LinkFail)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic so_mdo [0:127];
  logic so_en  [0:127];
  int   pulses;
  bit   done_seen;
  bit   saw_busy, saw_done;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] pack_mdo(input int from, input int len);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < len; i++) r = {r[62:0], so_mdo[from+i]};
    return r;
  endfunction

  function automatic logic [63:0] pack_en(input int from, input int len);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < len; i++) r = {r[62:0], so_en[from+i]};
    return r;
  endfunction

  // Called at a negedge; Start is seen by the next posedge.
  task automatic start_frame(input logic [1:0] op, input logic cl45, input logic nopre,
                             input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
    Op = op; NoPre = nopre; PhyAddr = pa; RegAddr = ra; WrData = wd;
`ifdef ETH_MDIO_CL45_EN
    Cl45 = cl45;
`else
    if (cl45) Op = op;
`endif
    Start = 1'b1; MdcEn_n = 1'b0;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Pulses MdcEn_n every 4th clock, records the slot values, feeds Mdi in
  // the DATA slots and stops on Done, on abort_at pulses, or on the budget.
  task automatic run_frame(input int pre, input logic [15:0] mdi_val, input int mid_start,
                           input int abort_at);
    int s;
    pulses = 0; done_seen = 1'b0; Mdi = 1'b0;
    for (int cyc = 0; cyc < 4 * (pre + 40); cyc++) begin
      if (Done) begin done_seen = 1'b1; MdcEn_n = 1'b0; break; end
      if (abort_at > 0 && pulses == abort_at) begin MdcEn_n = 1'b0; break; end
      Start = (mid_start > 0 && pulses == mid_start && (cyc % 4) == 0);
      if ((cyc % 4) == 3) begin
        if (pulses >= 1) begin
          s = pulses - 1;
          so_mdo[s] = Mdo; so_en[s] = MdoEn;
          if (s >= pre + 16 && s < pre + 32) Mdi = mdi_val[15 - (s - pre - 16)];
        end
        pulses++;
        MdcEn_n = 1'b1;
      end else begin
        MdcEn_n = 1'b0;
      end
      @(negedge Clk);
    end
    Start = 1'b0;
  endtask

  task automatic idle_pulses(input int n);
    saw_busy = 1'b0; saw_done = 1'b0;
    for (int cyc = 0; cyc < n; cyc++) begin
      if (Busy) saw_busy = 1'b1;
      if (Done) saw_done = 1'b1;
      MdcEn_n = ((cyc % 4) == 3);
      @(negedge Clk);
    end
    MdcEn_n = 1'b0;
  endtask

  initial begin
    Reset_n = 1'b0; MdcEn_n = 1'b0; Start = 1'b0; NoPre = 1'b0; Mdi = 1'b0;
    Op = 2'b00; PhyAddr = 5'd0; RegAddr = 5'd0; WrData = 16'd0;
`ifdef ETH_MDIO_CL45_EN
    Cl45 = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    check_eq("rst_mdo", Mdo, 1'b1);
    check_eq("rst_mdoen", MdoEn, 1'b0);
    check_eq("rst_busy", Busy, 1'b0);
    check_eq("rst_done", Done, 1'b0);
    check_eq("rst_rddata", RdData, 16'h0000);
    check_eq("rst_linkfail", LinkFail, 1'b0);

    // Clause 22 write with full preamble
    start_frame(2'b01, 1'b0, 1'b0, 5'h03, 5'h00, 16'h1200);
    check_eq("wr_busy_after_start", Busy, 1'b1);
    run_frame(32, 16'h0000, 0, 0);
    check_eq("wr_done_seen", done_seen, 1'b1);
    check_eq("wr_pulses", pulses, 65);
    check_eq("wr_pre", pack_mdo(0, 32), 64'hFFFF_FFFF);
    check_eq("wr_cmd", pack_mdo(32, 14), 64'h1460);
    check_eq("wr_ta", pack_mdo(46, 2), 64'h2);
    check_eq("wr_data", pack_mdo(48, 16), 64'h1200);
    check_eq("wr_mdoen", pack_en(0, 64), 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("wr_busy_at_done", Busy, 1'b0);
    check_eq("wr_rdvalid", RdValid, 1'b0);
    @(negedge Clk);
    check_eq("wr_done_one_cycle", Done, 1'b0);
    check_eq("wr_idle_mdo", Mdo, 1'b1);
    check_eq("wr_idle_mdoen", MdoEn, 1'b0);

    // Clause 22 read of the link register, link bit 0
    start_frame(2'b10, 1'b0, 1'b0, 5'h03, 5'h01, 16'h0000);
    run_frame(32, 16'h7809, 0, 0);
    check_eq("rd1_pulses", pulses, 65);
    check_eq("rd1_cmd", pack_mdo(32, 14), 64'h1861);
    check_eq("rd1_en_pre_cmd", pack_en(0, 46), 64'h3FFF_FFFF_FFFF);
    check_eq("rd1_en_ta_data", pack_en(46, 18), 64'h0);
    check_eq("rd1_rddata", RdData, 16'h7809);
    check_eq("rd1_rdvalid", RdValid, 1'b1);
    check_eq("rd1_linkfail", LinkFail, 1'b1);
    @(negedge Clk);
    check_eq("rd1_rdvalid_one_cycle", RdValid, 1'b0);

    // Link register read with link bit 1, then another register
    start_frame(2'b10, 1'b0, 1'b0, 5'h03, 5'h01, 16'h0000);
    run_frame(32, 16'h782D, 0, 0);
    check_eq("rd2_rddata", RdData, 16'h782D);
    check_eq("rd2_linkfail", LinkFail, 1'b0);
    @(negedge Clk);
    start_frame(2'b10, 1'b0, 1'b0, 5'h03, 5'h02, 16'h0000);
    run_frame(32, 16'h0000, 0, 0);
    check_eq("rd3_rddata", RdData, 16'h0000);
    check_eq("rd3_rdvalid", RdValid, 1'b1);
    check_eq("rd3_linkfail", LinkFail, 1'b0);
    @(negedge Clk);

    // No-preamble read with a stray Start mid-frame, then Start on Done
    start_frame(2'b10, 1'b0, 1'b1, 5'h01, 5'h04, 16'h0000);
    Op = 2'b01; PhyAddr = 5'h1F; RegAddr = 5'h1F; WrData = 16'hFFFF;
    run_frame(0, 16'hA5C3, 10, 0);
    check_eq("np_pulses", pulses, 33);
    check_eq("np_cmd", pack_mdo(0, 14), 64'h1824);
    check_eq("np_rddata", RdData, 16'hA5C3);
    check_eq("np_linkfail", LinkFail, 1'b0);
    start_frame(2'b01, 1'b0, 1'b1, 5'h01, 5'h04, 16'h5A0F);
    check_eq("done_cycle_start_busy", Busy, 1'b1);
    run_frame(0, 16'h0000, 0, 0);
    check_eq("np_wr_pulses", pulses, 33);
    check_eq("np_wr_ta", pack_mdo(14, 2), 64'h2);
    check_eq("np_wr_data", pack_mdo(16, 16), 64'h5A0F);
    check_eq("np_wr_rddata_kept", RdData, 16'hA5C3);
    @(negedge Clk);

`ifdef ETH_MDIO_CL45_EN
    // Clause 45 address frame
    start_frame(2'b00, 1'b1, 1'b1, 5'h02, 5'h05, 16'hABCD);
    check_eq("c45_busy", Busy, 1'b1);
    run_frame(0, 16'h0000, 0, 0);
    check_eq("c45_st", pack_mdo(0, 2), 64'h0);
    check_eq("c45_cmd", pack_mdo(0, 14), 64'h0045);
    check_eq("c45_data", pack_mdo(16, 16), 64'hABCD);
    check_eq("c45_mdoen", pack_en(0, 32), 64'hFFFF_FFFF);
    @(negedge Clk);
`else
    // Clause 22 rejects op codes 11 and 00
    start_frame(2'b11, 1'b0, 1'b1, 5'h02, 5'h05, 16'hABCD);
    idle_pulses(40);
    check_eq("op11_no_busy", saw_busy, 1'b0);
    check_eq("op11_no_done", saw_done, 1'b0);
    start_frame(2'b00, 1'b0, 1'b1, 5'h02, 5'h05, 16'hABCD);
    idle_pulses(40);
    check_eq("op00_no_busy", saw_busy, 1'b0);
`endif

    // Reset in the DATA state of a read
    start_frame(2'b10, 1'b0, 1'b1, 5'h01, 5'h01, 16'h0000);
    run_frame(0, 16'hFFFF, 0, 20);
    check_eq("abort_busy_before", Busy, 1'b1);
    check_eq("abort_mdoen_before", MdoEn, 1'b0);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    check_eq("abort_busy", Busy, 1'b0);
    check_eq("abort_mdo", Mdo, 1'b1);
    check_eq("abort_mdoen", MdoEn, 1'b0);
    check_eq("abort_rddata", RdData, 16'h0000);
    check_eq("abort_done", Done, 1'b0);
    check_eq("abort_linkfail", LinkFail, 1'b0);
    idle_pulses(80);
    check_eq("abort_no_done_after", saw_done, 1'b0);
    check_eq("abort_no_busy_after", saw_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_mdio_engine.md
# eth_mdio_engine

Parametrised MII management (MDIO) frame engine. It is the next generation of the byte-loaded management shift register. It builds and serialises a complete management frame from a single `Start` request: preamble, start/op/address fields, turnaround and data. It captures read data and derives link status. It sits between the MII management register block and the MDC/MDIO pads, and is paced by the existing MDC clock generator enable.

## Interface
- `PRE_LEN`, 32, number of preamble '1' slots (1..63)
- `LINK_REG`, 5'h01, register address whose read updates `LinkFail`
- `LINK_BIT`, 2, bit index of link status within read data (0..15)
- `Clk`  in  1  host clock
- `Reset_n`  in  1  reset; one clock, reset is synchronous and active-low
- `MdcEn_n`  in  1  one-`Clk` pulse per MDC period, asserted before MDC falls; each pulse ends one bit slot
- `Start`  in  1  request; sampled only in IDLE
- `Op`  in  2  operation code
- `Cl45`  in  1  Clause 45 frame select (present only with `ETH_MDIO_CL45_EN`)
- `NoPre`  in  1  suppress preamble
- `PhyAddr`  in  5  PHY / port address
- `RegAddr`  in  5  register / device address
- `WrData`  in  16  write data or Clause 45 address
- `Mdi`  in  1  MDIO input
- `Mdo`  out  1  MDIO output data
- `MdoEn`  out  1  MDIO output enable
- `Busy`  out  1  frame in progress
- `Done`  out  1  one-cycle pulse at frame end
- `RdData`  out  16  last read data
- `RdValid`  out  1  one-cycle pulse with `Done` on read frames
- `LinkFail`  out  1  inverted link status

## Operation
- States: IDLE, PRE, CMD, TA, DATA.
- IDLE → PRE on accepted `Start`. IDLE → CMD if `NoPre`=1.
- PRE → CMD after `PRE_LEN` slots. CMD → TA after 14 slots. TA → DATA after 2 slots. DATA → IDLE after 16 slots.
- All inputs are latched when `Start` is accepted. Later input changes do not affect the frame.
- CMD bits, MSB first: ST[1:0], OP[1:0], PhyAddr[4:0], RegAddr[4:0].
  - ST=01 in Clause 22.
  - ST=00 in Clause 45.
- Clause 22 operations:
  - Op=01 is a write; Op=10 is a read.
  - Op=00 and Op=11 are rejected. `Start` is ignored, and no `Busy` or `Done` is produced.
- Clause 45 operations:
  - 00 is address, 01 is write, 11 is read, 10 is read-increment.
  - All four are accepted.
- Write and address frames:
  - TA drives 1 then 0.
  - DATA drives the latched `WrData`, MSB first.
  - `MdoEn`=1 for the whole frame.
- Read frames:
  - `MdoEn`=1 through PRE and CMD, and 0 during TA and DATA.
  - `Mdi` is shifted in MSB first, one bit per DATA slot.
- Read completion:
  - `RdData` is updated in the same cycle as `Done`.
  - `RdValid` pulses with `Done`.
  - If the latched RegAddr equals `LINK_REG`, `LinkFail` is set to the inverse of the new `RdData[LINK_BIT]`.
  - Other reads and writes leave `LinkFail` unchanged.
- `Start` while `Busy` is ignored.
- A slot counter of 6 bits counts slots within each state. It wraps to 0 on every state transition.

## Timing
- Reset values, applied on any `Clk` edge with `Reset_n`=0, including mid-frame:
  - State IDLE.
  - `Mdo`=1, `MdoEn`=0, `Busy`=0, `Done`=0, `RdValid`=0.
  - `RdData`=0, `LinkFail`=0.
  - Slot counter 0.
- `Start` accepted at edge t → `Busy`=1 from t+1.
- Slot i begins at the `MdcEn_n` pulse that follows the previous slot. `Mdo`/`MdoEn` are registered and update in the cycle after that pulse. They are held for the entire slot.
- `Mdi` for a DATA slot is sampled on the `MdcEn_n` pulse that ends that slot.
- A frame of N slots consumes N+1 `MdcEn_n` pulses.
  - N = `PRE_LEN`+32, or 32 when `NoPre`=1.
- `Done` pulses in the cycle after the final pulse, and `Busy` falls in the same cycle.
- A new `Start` may be accepted in the cycle `Done` is high.
- `MdcEn_n` held low stalls the engine indefinitely with outputs stable.
- In IDLE: `Mdo`=1, `MdoEn`=0.

## Configuration
- `ETH_MDIO_CL45_EN` defined:
  - `Cl45` port exists.
  - With `Cl45`=1, ST=00 and all four Op codes are valid.
- `ETH_MDIO_CL45_EN` undefined:
  - `Cl45` port is absent and the engine is Clause 22 only.
  - ST is fixed at 01, and Op 00/11 are rejected as above.

## Structure
- Shared package `eth_mdio_pkg`:
  - State enum.
  - ST constants (ST_C22=2'b01, ST_C45=2'b00).
  - Op code constants for both clauses.
  - Field widths (CMD_LEN=14, TA_LEN=2, DATA_LEN=16).
- One sub-module, `eth_mdio_rxshift`: 16-bit serial-to-parallel capture, enabled per DATA slot on read frames, with parallel output to `RdData`.

## Test plan
- Clause 22 write, PhyAddr=5'h03, RegAddr=5'h00, WrData=16'h1200, `NoPre`=0, PRE_LEN=32 → serial stream of 32 ones then 01 01 00011 00000 10 0001001000000000; `MdoEn`=1 throughout; `Done` after the 65th `MdcEn_n`.
- Clause 22 read of RegAddr=5'h01, `Mdi` driving 16'h7809 → `MdoEn`=0 from TA onward; `RdData`=16'h7809; `RdValid` pulses; `LinkFail`=1 (bit 2 is 0).
- Read of RegAddr=5'h01 returning 16'h782D → `LinkFail`=0. A following read of RegAddr=5'h02 returning 16'h0000 → `LinkFail` stays 0.
- `NoPre`=1 read → `Done` after 33 `MdcEn_n` pulses. A second `Start` issued mid-frame is ignored; a `Start` issued on the `Done` cycle is accepted.
- With `ETH_MDIO_CL45_EN`, `Cl45`=1, Op=00, WrData=16'hABCD → ST bits 00, data field ABCD. With the macro undefined, Op=11 → `Busy` stays 0.
- `Reset_n` low during the DATA state of a read → next cycle IDLE, `Mdo`=1, `MdoEn`=0, `RdData`=0, no `Done`.
